// File: rtl/riscv_mport_regfile.sv
// Multi-port integer register file: N_RD combinational reads, N_WR prioritised
// writes, per-register pending bit, optional write-to-read bypass, soft-clear sweep.
//
// state    | meaning
// S_IDLE   | normal operation, writes and pset accepted, clr_req_i sampled
// S_CLEAR  | sweep zeroes mem/pend at cnt each cycle, writes and pset dropped
// S_DONE   | one-cycle completion pulse, writes accepted again
module riscv_mport_regfile #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int N_RD       = 3,
  parameter int N_WR       = 2,
  parameter bit BYPASS     = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_RD*ADDR_WIDTH-1:0] raddr_i,
  output logic [N_RD*DATA_WIDTH-1:0] rdata_o,
  output logic [N_RD-1:0]            rpend_o,
  input  logic [N_WR*ADDR_WIDTH-1:0] waddr_i,
  input  logic [N_WR*DATA_WIDTH-1:0] wdata_i,
  input  logic [N_WR-1:0]            we_i,
  input  logic                       pset_i,
  input  logic [ADDR_WIDTH-1:0]      pset_addr_i,
  input  logic                       clr_req_i,
  output logic                       wr_ready_o,
  output logic                       clr_busy_o,
  output logic                       clr_done_o
);

  localparam int NUM_WORDS = 2**ADDR_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
  logic [NUM_WORDS-1:0]  pend;

  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] waddr [N_WR];
  logic [DATA_WIDTH-1:0] wdata [N_WR];
  logic [N_WR-1:0]       wr_acc;
  logic                  pset_acc;

  assign wr_ready   = (state != S_CLEAR);
  assign wr_ready_o = wr_ready;
  assign clr_busy_o = (state == S_CLEAR);
  assign clr_done_o = (state == S_DONE);

  for (genvar j = 0; j < N_WR; j++) begin : g_wr
    assign waddr[j]  = waddr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata[j]  = wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
    assign wr_acc[j] = we_i[j] && wr_ready && (waddr[j] != '0);
  end

  assign pset_acc = pset_i && wr_ready && (pset_addr_i != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clr_req_i) begin
            state <= S_CLEAR;
            cnt   <= ADDR_WIDTH'(1);
          end
        end
        S_CLEAR: begin
          if (cnt == ADDR_WIDTH'(NUM_WORDS - 1)) state <= S_DONE;
          else                                   cnt   <= cnt + 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Ascending port order lets the highest-index write win; pset is last so it beats a write-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
      pend <= '0;
    end else if (state == S_CLEAR) begin
      mem[cnt]  <= '0;
      pend[cnt] <= 1'b0;
    end else begin
      for (int j = 0; j < N_WR; j++) begin
        if (wr_acc[j]) begin
          mem[waddr[j]]  <= wdata[j];
          pend[waddr[j]] <= 1'b0;
        end
      end
      if (pset_acc) pend[pset_addr_i] <= 1'b1;
    end
  end

  // Entry 0 is never written (address 0 writes are rejected, the sweep starts at 1), so it stays zero.
  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;

    assign ra = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd = mem[ra];
      if (BYPASS) begin
        for (int j = 0; j < N_WR; j++) begin
          if (wr_acc[j] && (waddr[j] == ra)) rd = wdata[j];
        end
      end
    end

    assign rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = rd;
    assign rpend_o[k]                          = pend[ra];
  end

endmodule

// File: tb/tb_riscv_mport_regfile.sv
// Directed and randomised checks of riscv_mport_regfile: two default-size
// instances (BYPASS 0 and 1) sharing stimulus, plus a 6-read/4-write instance.
module tb_riscv_mport_regfile;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int NR  = 3;
  localparam int NW  = 2;
  localparam int AW2 = 4;
  localparam int NR2 = 6;
  localparam int NW2 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata_a, rdata_b;
  logic [NR-1:0]    rpend_a, rpend_b;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NW-1:0]    we;
  logic             pset;
  logic [AW-1:0]    pset_addr;
  logic             clr_req;
  logic             wr_ready_a, clr_busy_a, clr_done_a;
  logic             wr_ready_b, clr_busy_b, clr_done_b;

  logic [NR2*AW2-1:0] raddr2;
  logic [NR2*DW-1:0]  rdata2;
  logic [NR2-1:0]     rpend2;
  logic [NW2*AW2-1:0] waddr2;
  logic [NW2*DW-1:0]  wdata2;
  logic [NW2-1:0]     we2;
  logic               pset2;
  logic [AW2-1:0]     pset_addr2;
  logic               clr_req2;
  logic               wr_ready2, clr_busy2, clr_done2;

  int checks = 0;
  int errors = 0;

  riscv_mport_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_RD(NR), .N_WR(NW), .BYPASS(1'b0)) dut_a (
    .clk(clk), .rst(rst), .raddr_i(raddr), .rdata_o(rdata_a), .rpend_o(rpend_a),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .pset_i(pset), .pset_addr_i(pset_addr),
    .clr_req_i(clr_req), .wr_ready_o(wr_ready_a), .clr_busy_o(clr_busy_a), .clr_done_o(clr_done_a)
  );

  riscv_mport_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_RD(NR), .N_WR(NW), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .raddr_i(raddr), .rdata_o(rdata_b), .rpend_o(rpend_b),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .pset_i(pset), .pset_addr_i(pset_addr),
    .clr_req_i(clr_req), .wr_ready_o(wr_ready_b), .clr_busy_o(clr_busy_b), .clr_done_o(clr_done_b)
  );

  riscv_mport_regfile #(.ADDR_WIDTH(AW2), .DATA_WIDTH(DW), .N_RD(NR2), .N_WR(NW2), .BYPASS(1'b1)) dut_c (
    .clk(clk), .rst(rst), .raddr_i(raddr2), .rdata_o(rdata2), .rpend_o(rpend2),
    .waddr_i(waddr2), .wdata_i(wdata2), .we_i(we2), .pset_i(pset2), .pset_addr_i(pset_addr2),
    .clr_req_i(clr_req2), .wr_ready_o(wr_ready2), .clr_busy_o(clr_busy2), .clr_done_o(clr_done2)
  );

  function automatic logic [DW-1:0] rda(input int k);
    return rdata_a[k*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] rdb(input int k);
    return rdata_b[k*DW +: DW];
  endfunction

  task automatic clear_in();
    raddr = '0; waddr = '0; wdata = '0; we = '0;
    pset = 1'b0; pset_addr = '0; clr_req = 1'b0;
  endtask

  task automatic set_w(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    waddr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
    we[p] = 1'b1;
  endtask

  task automatic set_r(input int k, input logic [AW-1:0] a);
    raddr[k*AW +: AW] = a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_in();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({wr_ready_a, clr_busy_a, clr_done_a} !== 3'b100 || {wr_ready_b, clr_busy_b, clr_done_b} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: got a=%b b=%b expected 100", {wr_ready_a, clr_busy_a, clr_done_a},
               {wr_ready_b, clr_busy_b, clr_done_b});
    end
    @(negedge clk);
    rst = 1'b0;
    set_w(0, 5'd0, 32'hDEADBEEF);
    set_w(1, 5'd0, 32'hDEADBEEF);
    pset = 1'b1;
    pset_addr = 5'd0;
    #1;
    checks++;
    if (rdb(0) !== 32'h0) begin
      errors++;
      $display("FAIL x0_bypass: got %h expected 0", rdb(0));
    end
    @(posedge clk);
    @(negedge clk);
    clear_in();
    set_r(0, 5'd0); set_r(1, 5'd1); set_r(2, 5'd31);
    #1;
    for (int k = 0; k < NR; k++) begin
      checks++;
      if (rda(k) !== 32'h0 || rdb(k) !== 32'h0 || rpend_a[k] !== 1'b0 || rpend_b[k] !== 1'b0) begin
        errors++;
        $display("FAIL x0_read port%0d: got a=%h b=%h pend=%b%b expected 0", k, rda(k), rdb(k), rpend_a[k], rpend_b[k]);
      end
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    clear_in();
    set_w(0, 5'd5, 32'h11);
    set_w(1, 5'd5, 32'h22);
    set_r(0, 5'd5);
    #1;
    checks++;
    if (rda(0) !== 32'h0) begin
      errors++;
      $display("FAIL prio_nobypass: got %h expected 0", rda(0));
    end
    checks++;
    if (rdb(0) !== 32'h22) begin
      errors++;
      $display("FAIL prio_bypass: got %h expected 22", rdb(0));
    end
    @(negedge clk);
    clear_in();
    set_w(0, 5'd6, 32'h66);
    set_w(1, 5'd9, 32'h99);
    set_r(0, 5'd6); set_r(1, 5'd9); set_r(2, 5'd5);
    #1;
    checks++;
    if (rda(0) !== 32'h0 || rda(1) !== 32'h0 || rda(2) !== 32'h22) begin
      errors++;
      $display("FAIL prio_commit_a: got %h %h %h expected 0 0 22", rda(0), rda(1), rda(2));
    end
    checks++;
    if (rdb(0) !== 32'h66 || rdb(1) !== 32'h99 || rdb(2) !== 32'h22) begin
      errors++;
      $display("FAIL multi_bypass_b: got %h %h %h expected 66 99 22", rdb(0), rdb(1), rdb(2));
    end
    @(negedge clk);
    clear_in();
    set_r(0, 5'd6); set_r(1, 5'd9);
    #1;
    checks++;
    if (rda(0) !== 32'h66 || rda(1) !== 32'h99) begin
      errors++;
      $display("FAIL two_port_commit: got %h %h expected 66 99", rda(0), rda(1));
    end
  endtask

  task automatic test_pending();
    @(negedge clk);
    clear_in();
    pset = 1'b1; pset_addr = 5'd7;
    set_r(0, 5'd7);
    #1;
    checks++;
    if (rpend_a[0] !== 1'b0 || rpend_b[0] !== 1'b0) begin
      errors++;
      $display("FAIL pend_same_cycle: got %b%b expected 00", rpend_a[0], rpend_b[0]);
    end
    @(negedge clk);
    clear_in();
    set_r(0, 5'd7);
    #1;
    checks++;
    if (rpend_a[0] !== 1'b1 || rpend_b[0] !== 1'b1) begin
      errors++;
      $display("FAIL pend_set: got %b%b expected 11", rpend_a[0], rpend_b[0]);
    end
    set_w(0, 5'd7, 32'h77);
    @(negedge clk);
    clear_in();
    set_r(0, 5'd7);
    #1;
    checks++;
    if (rpend_a[0] !== 1'b0 || rda(0) !== 32'h77) begin
      errors++;
      $display("FAIL pend_clr_by_write: got pend=%b data=%h expected 0 77", rpend_a[0], rda(0));
    end
    set_w(1, 5'd7, 32'h78);
    pset = 1'b1; pset_addr = 5'd7;
    @(negedge clk);
    clear_in();
    set_r(0, 5'd7);
    #1;
    checks++;
    if (rpend_a[0] !== 1'b1 || rpend_b[0] !== 1'b1 || rda(0) !== 32'h78) begin
      errors++;
      $display("FAIL pend_set_wins: got pend=%b%b data=%h expected 11 78", rpend_a[0], rpend_b[0], rda(0));
    end
  endtask

  task automatic test_sweep();
    int busy_cnt;
    int done_n;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      clear_in();
      set_w(0, AW'(i), DW'(i));
      pset = 1'b1; pset_addr = AW'(i);
    end
    @(negedge clk);
    clear_in();
    clr_req = 1'b1;
    set_w(1, 5'd20, 32'hAAAA);
    set_r(0, 5'd31); set_r(1, 5'd12);
    #1;
    checks++;
    if (rda(0) !== 32'd31 || rda(1) !== 32'd12 || rpend_a[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL fill: got %h %h pend=%b expected 1f 0c 11", rda(0), rda(1), rpend_a[1:0]);
    end
    @(posedge clk);
    busy_cnt = 0;
    done_n = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      clear_in();
      clr_req = (n == 10);
      set_w(0, 5'd3, 32'h333);
      set_r(0, 5'd3); set_r(1, 5'd20); set_r(2, 5'd5);
      #1;
      checks++;
      if (wr_ready_a !== ~clr_busy_a || clr_busy_b !== clr_busy_a) begin
        errors++;
        $display("FAIL sweep_ready cycle%0d: got ready=%b busy=%b busy_b=%b", n, wr_ready_a, clr_busy_a, clr_busy_b);
      end
      if (n == 5) begin
        checks++;
        if (rda(0) !== 32'h0 || rda(1) !== 32'hAAAA || rda(2) !== 32'd5 || rdb(0) !== 32'h0) begin
          errors++;
          $display("FAIL sweep_mid: got %h %h %h b=%h expected 0 aaaa 5 0", rda(0), rda(1), rda(2), rdb(0));
        end
      end
      if (clr_done_a === 1'b1) begin
        done_n = n;
        break;
      end
      if (clr_busy_a === 1'b1) busy_cnt++;
    end
    checks++;
    if (done_n !== 32 || busy_cnt !== 31) begin
      errors++;
      $display("FAIL sweep_len: got done_cycle=%0d busy=%0d expected 32 31", done_n, busy_cnt);
    end
    checks++;
    if (wr_ready_a !== 1'b1 || clr_done_b !== 1'b1 || rda(0) !== 32'h0 || rdb(0) !== 32'h333) begin
      errors++;
      $display("FAIL done_cycle: got ready=%b done_b=%b a=%h b=%h expected 1 1 0 333", wr_ready_a, clr_done_b, rda(0), rdb(0));
    end
    @(negedge clk);
    clear_in();
    #1;
    checks++;
    if (clr_done_a !== 1'b0 || clr_busy_a !== 1'b0) begin
      errors++;
      $display("FAIL after_done: got done=%b busy=%b expected 0 0", clr_done_a, clr_busy_a);
    end
    for (int i = 1; i < 32; i++) begin
      set_r(0, AW'(i));
      #1;
      checks++;
      if (rda(0) !== ((i == 3) ? 32'h333 : 32'h0) || rpend_a[0] !== 1'b0 || rpend_b[0] !== 1'b0) begin
        errors++;
        $display("FAIL swept x%0d: got %h pend=%b%b", i, rda(0), rpend_a[0], rpend_b[0]);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit seen;
    @(negedge clk);
    clear_in();
    set_w(0, 5'd4, 32'h44);
    set_w(1, 5'd30, 32'h30);
    pset = 1'b1; pset_addr = 5'd30;
    @(negedge clk);
    clear_in();
    clr_req = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      clear_in();
    end
    set_r(0, 5'd4); set_r(1, 5'd30);
    #1;
    checks++;
    if (clr_busy_a !== 1'b1 || rda(0) !== 32'h0 || rda(1) !== 32'h30 || rpend_a[1] !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_sweep: got busy=%b %h %h pend=%b expected 1 0 30 1", clr_busy_a, rda(0), rda(1), rpend_a[1]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({wr_ready_a, clr_busy_a, clr_done_a} !== 3'b100 || rda(1) !== 32'h0 || rpend_a[1] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_sweep: got flags=%b x30=%h pend=%b expected 100 0 0", {wr_ready_a, clr_busy_a, clr_done_a},
               rda(1), rpend_a[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (clr_done_a === 1'b1 || clr_busy_a === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL no_done_after_rst: got activity=%b expected 0", seen);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0]  mdl [16];
    logic [15:0]    pmdl;
    logic [AW2-1:0] a;
    logic [AW2-1:0] wa;
    logic [DW-1:0]  exp_d;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    pmdl = '0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      we2 = NW2'($urandom);
      for (int j = 0; j < NW2; j++) begin
        waddr2[j*AW2 +: AW2] = AW2'($urandom);
        wdata2[j*DW +: DW]   = $urandom;
      end
      pset2 = ($urandom_range(0, 3) == 0);
      pset_addr2 = AW2'($urandom);
      for (int k = 0; k < NR2; k++) raddr2[k*AW2 +: AW2] = AW2'($urandom);
      #1;
      for (int k = 0; k < NR2; k++) begin
        a = raddr2[k*AW2 +: AW2];
        exp_d = mdl[a];
        for (int j = 0; j < NW2; j++) begin
          wa = waddr2[j*AW2 +: AW2];
          if (we2[j] && wa != 0 && wa == a) exp_d = wdata2[j*DW +: DW];
        end
        checks++;
        if (rdata2[k*DW +: DW] !== exp_d || rpend2[k] !== pmdl[a]) begin
          errors++;
          $display("FAIL rand c%0d port%0d x%0d: got %h pend=%b expected %h pend=%b", c, k, a,
                   rdata2[k*DW +: DW], rpend2[k], exp_d, pmdl[a]);
        end
      end
      checks++;
      if (wr_ready2 !== 1'b1) begin
        errors++;
        $display("FAIL rand_ready c%0d: got %b expected 1", c, wr_ready2);
      end
      for (int j = 0; j < NW2; j++) begin
        wa = waddr2[j*AW2 +: AW2];
        if (we2[j] && wa != 0) begin
          mdl[wa]  = wdata2[j*DW +: DW];
          pmdl[wa] = 1'b0;
        end
      end
      if (pset2 && pset_addr2 != 0) pmdl[pset_addr2] = 1'b1;
    end
    @(negedge clk);
    we2 = '0;
    pset2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    raddr2 = '0; waddr2 = '0; wdata2 = '0; we2 = '0;
    pset2 = 1'b0; pset_addr2 = '0; clr_req2 = 1'b0;
    test_reset();
    test_priority();
    test_pending();
    test_sweep();
    test_reset_mid_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
